// File: rtl/dcache_port_arb.sv
// dcache_port_arb: arbitrates a load channel and a store channel onto a single
// memory request/response port. One operation is in flight at a time; stores
// win over loads when both are offered in the same idle cycle.
module dcache_port_arb #(
    parameter int INDEX_W = 19,
    parameter int DATA_W  = 64
) (
    input  logic               clock,
    input  logic               reset_n,

    input  logic               opload_index_valid,
    input  logic [INDEX_W-1:0] opload_index,
    output logic               opload_index_ready,
    output logic [DATA_W-1:0]  opload_read_data,
    output logic               opload_operation_done,

    input  logic               opstore_index_valid,
    input  logic [INDEX_W-1:0] opstore_index,
    input  logic [DATA_W-1:0]  opstore_write_mask,
    input  logic [DATA_W-1:0]  opstore_write_data,
    output logic               opstore_index_ready,
    output logic               opstore_operation_done,

    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic               mem_req_wen,
    output logic [INDEX_W-1:0] mem_req_index,
    output logic [DATA_W-1:0]  mem_req_wdata,
    output logic [DATA_W-1:0]  mem_req_wmask,
    input  logic               mem_resp_valid,
    input  logic [DATA_W-1:0]  mem_resp_rdata,

    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t             state;
    logic               op_wen;
    logic [INDEX_W-1:0] op_index;
    logic [DATA_W-1:0]  op_wdata;
    logic [DATA_W-1:0]  op_wmask;
    logic [DATA_W-1:0]  read_data;

    // Acceptance is only offered while idle and out of reset; the store channel
    // shadows the load channel so a simultaneous load waits for the next idle cycle.
    assign opstore_index_ready = reset_n && (state == IDLE) && opstore_index_valid;
    assign opload_index_ready  = reset_n && (state == IDLE) && opload_index_valid
                                 && !opstore_index_valid;

    // Memory request fields come only from the captured operation so that the
    // channel inputs are free to change once the request has been taken.
    assign mem_req_valid = (state == REQ);
    assign mem_req_wen   = op_wen;
    assign mem_req_index = op_index;
    assign mem_req_wdata = op_wdata;
    assign mem_req_wmask = op_wmask;

    // Completion pulses last exactly the single DONE cycle and go to the
    // channel that owns the operation.
    assign opload_operation_done  = (state == DONE) && !op_wen;
    assign opstore_operation_done = (state == DONE) && op_wen;
    assign opload_read_data       = read_data;
    assign busy                   = (state != IDLE);

    // Operation sequencer: capture, issue, wait for the response, then signal done.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_wen    <= 1'b0;
            op_index  <= '0;
            op_wdata  <= '0;
            op_wmask  <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (opstore_index_valid) begin
                        op_wen   <= 1'b1;
                        op_index <= opstore_index;
                        op_wdata <= opstore_write_data;
                        op_wmask <= opstore_write_mask;
                        state    <= REQ;
                    end else if (opload_index_valid) begin
                        op_wen   <= 1'b0;
                        op_index <= opload_index;
                        op_wdata <= '0;
                        op_wmask <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (mem_resp_valid) begin
                        if (!op_wen) begin
                            read_data <= mem_resp_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dcache_port_arb.md
DCACHE_PORT_ARB -- requirements
Module: dcache_port_arb

Interface
REQ-001 Parameter INDEX_W, default 19, SHALL set line-index width.
REQ-002 Parameter DATA_W, default 64, SHALL set data and mask width.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports SHALL be:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- opload_index_valid  in  1  load request
- opload_index  in  INDEX_W  load line index
- opload_index_ready  out  1  load request accepted
- opload_read_data  out  DATA_W  load result
- opload_operation_done  out  1  load complete pulse
- opstore_index_valid  in  1  store request
- opstore_index  in  INDEX_W  store line index
- opstore_write_mask  in  DATA_W  store byte-lane bit mask
- opstore_write_data  in  DATA_W  store data
- opstore_index_ready  out  1  store request accepted
- opstore_operation_done  out  1  store complete pulse
- mem_req_valid  out  1  memory port request
- mem_req_ready  in  1  memory port accept
- mem_req_wen  out  1  1 = write, 0 = read
- mem_req_index  out  INDEX_W  memory index
- mem_req_wdata  out  DATA_W  write data
- mem_req_wmask  out  DATA_W  write mask
- mem_resp_valid  in  1  memory response (read data or write ack)
- mem_resp_rdata  in  DATA_W  read data
- busy  out  1  state not IDLE

Function
REQ-005 The FSM SHALL have four states: IDLE, REQ, WAIT_RESP, DONE.
REQ-006 In IDLE, when opstore_index_valid=1, opstore_index_ready SHALL be 1 (combinational), opload_index_ready SHALL be 0, and the store SHALL be captured; next state is REQ.
REQ-007 In IDLE, when only opload_index_valid=1, opload_index_ready SHALL be 1, the load SHALL be captured, and next state is REQ.
REQ-008 Store SHALL have priority over load when both are valid in the same cycle; the load SHALL stay unaccepted until the next IDLE cycle.
REQ-009 Both ready outputs SHALL be 0 in every state other than IDLE.
REQ-010 Captured fields (wen, index, wdata, wmask) SHALL be registered; mem_req_* outputs SHALL be driven from these registers only, so later input changes have no effect.
REQ-011 In REQ, mem_req_valid SHALL be 1, with fields held stable until mem_req_ready=1.
REQ-012 When mem_req_valid & mem_req_ready, the FSM SHALL go to WAIT_RESP; mem_req_valid SHALL be 0 from the next cycle.
REQ-013 In WAIT_RESP, mem_resp_valid=1 SHALL move the FSM to DONE; for a read, mem_resp_rdata SHALL be latched into opload_read_data.
REQ-014 A response arriving in the same cycle as the request handshake SHALL NOT be accepted; only WAIT_RESP samples responses.
REQ-015 In DONE, exactly one one-cycle pulse SHALL occur: opload_operation_done if the captured op was a read, else opstore_operation_done; next state is IDLE.
REQ-016 opload_read_data SHALL hold its value until the next load completes; stores SHALL NOT alter it.
REQ-017 mem_resp_valid SHALL be ignored in IDLE, REQ and DONE.
REQ-018 Minimum latency, with ready and response immediate, SHALL be: accept in cycle T, mem_req_valid in T+1, response in T+2, done pulse in T+3; the next accept is possible in T+4.
REQ-019 mem_req_wdata and mem_req_wmask SHALL be 0 for reads.
REQ-020 busy SHALL be 1 exactly when the state is not IDLE.

Reset
REQ-021 When reset_n=0 at a clock edge, the state SHALL become IDLE and all registers 0; mem_req_valid, both done outputs, opload_read_data, mem_req_* fields and busy SHALL be 0 in the following cycle.
REQ-022 Reset in any state, including mid-handshake, SHALL abandon the operation with no done pulse; a late mem_resp_valid after reset SHALL be ignored.
REQ-023 While reset_n=0, both ready outputs SHALL be 0.

Verification
REQ-024 Load index 0x12345, mem_req_ready=1, response rdata 0xDEADBEEF_CAFEF00D one cycle after the handshake -> mem_req_wen=0 and index 0x12345; done pulse at T+3; opload_read_data=0xDEADBEEFCAFEF00D.
REQ-025 Store index 0x00042, mask 0x00000000000000FF, data 0x11 -> mem_req_wen=1 with matching fields; opstore_operation_done pulse only; opload_read_data unchanged.
REQ-026 Load and store valid in the same cycle -> store accepted first and completed; load accepted in the first IDLE cycle after the store's DONE.
REQ-027 mem_req_ready held 0 for 5 cycles in REQ -> mem_req_valid and all fields stable for 6 cycles; no ready to either channel.
REQ-028 Reset asserted in WAIT_RESP, then mem_resp_valid pulsed after reset is released -> no done pulse, state IDLE, busy=0.
REQ-029 Spurious mem_resp_valid in IDLE with rdata 0xFFFF -> no state change; opload_read_data keeps its prior value.
